// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: port request/response
// structs, arbiter state, pending-slot record and the default starvation limit.
package mem_arbiter_pkg;

    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_fence;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_type;

    typedef struct packed {
        logic        valid;
        logic        fence;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } pend_type;

    function automatic pend_type capture(mem_in_type req, logic side_instr);
        pend_type p;
        p.valid = req.mem_valid;
        p.fence = req.mem_fence;
        p.instr = req.mem_instr | side_instr;
        p.addr  = req.mem_addr;
        p.wdata = req.mem_wdata;
        p.wstrb = req.mem_wstrb;
        return p;
    endfunction

    function automatic mem_in_type to_mem(pend_type p);
        mem_in_type m;
        m.mem_valid = p.valid;
        m.mem_fence = p.fence;
        m.mem_instr = p.instr;
        m.mem_addr  = p.addr;
        m.mem_wdata = p.wdata;
        m.mem_wstrb = p.wstrb;
        return m;
    endfunction

endpackage

// File: rtl/mem_arb_slot.sv
// Per-port pending request slot: a new request overwrites a not-yet-issued one,
// and a grant clears it. eff presents the request the arbiter should see this cycle.
module mem_arb_slot
    import mem_arbiter_pkg::*;
#(
    parameter bit is_instr = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  mem_in_type req,
    input  logic       clr,
    output pend_type   eff
);

    logic     slot_valid;
    pend_type slot_data;

    // An incoming request supersedes whatever is parked, so it is visible immediately.
    always_comb begin
        if (req.mem_valid) begin
            eff = capture(req, is_instr);
        end else begin
            eff       = slot_data;
            eff.valid = slot_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot_valid <= 1'b0;
        end else if (clr) begin
            slot_valid <= 1'b0;
        end else if (req.mem_valid) begin
            slot_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (req.mem_valid) begin
            slot_data <= capture(req, is_instr);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single memory port between instruction fetch and data accesses;
// data wins unless instruction fetch has been passed over starve_limit times.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int starve_limit = STARVE_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  mem_in,
    input  mem_out_type mem_out
);

    localparam int            CW    = $clog2(starve_limit + 1);
    localparam logic [CW-1:0] LIMIT = CW'(starve_limit);

    typedef struct packed {
        arb_state_type state;
        logic [CW-1:0] cnt;
        mem_in_type    issue;
    } reg_type;

    reg_type  r, rin;
    pend_type ipend, dpend;
    logic     gnt_i, gnt_d, done;

    mem_arb_slot #(.is_instr(1'b1)) u_islot (
        .clk (clk),
        .rst (rst),
        .req (imem_in),
        .clr (gnt_i),
        .eff (ipend)
    );

    mem_arb_slot #(.is_instr(1'b0)) u_dslot (
        .clk (clk),
        .rst (rst),
        .req (dmem_in),
        .clr (gnt_d),
        .eff (dpend)
    );

    always_comb begin
        rin                 = r;
        rin.issue.mem_valid = 1'b0;
        gnt_i               = 1'b0;
        gnt_d               = 1'b0;
        imem_out            = '0;
        dmem_out            = '0;
        done                = rst && (r.state != IDLE) && mem_out.mem_ready;

        // A completing transaction frees the port for a grant on the same edge.
        if (r.state == IDLE || done) begin
            if (dpend.valid && (!ipend.valid || r.cnt != LIMIT)) begin
                gnt_d = 1'b1;
            end else if (ipend.valid) begin
                gnt_i = 1'b1;
            end
        end

        if (done) begin
            rin.state = IDLE;
            if (r.state == BUSY_I) begin
                imem_out.mem_ready = 1'b1;
                imem_out.mem_rdata = mem_out.mem_rdata;
            end else begin
                dmem_out.mem_ready = 1'b1;
                dmem_out.mem_rdata = mem_out.mem_rdata;
            end
        end

        if (gnt_i) begin
            rin.state = BUSY_I;
            rin.issue = to_mem(ipend);
            rin.cnt   = '0;
        end

        if (gnt_d) begin
            rin.state = BUSY_D;
            rin.issue = to_mem(dpend);
            if (ipend.valid && r.cnt != LIMIT) begin
                rin.cnt = r.cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r.state <= IDLE;
            r.cnt   <= '0;
            r.issue <= '0;
        end else begin
            r <= rin;
        end
    end

    assign mem_in = r.issue;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    mem_in_type  imem_in, dmem_in, mem_in;
    mem_out_type imem_out, dmem_out, mem_out;

    mem_arbiter #(.starve_limit(LIMIT)) dut (
        .clk      (clk),
        .rst      (rst),
        .imem_in  (imem_in),
        .imem_out (imem_out),
        .dmem_in  (dmem_in),
        .dmem_out (dmem_out),
        .mem_in   (mem_in),
        .mem_out  (mem_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: who owns memory (0 none, 1 instr, 2 data), what waits per side,
    // how many data grants have bypassed a waiting fetch, and the expected issue.
    int          m_owner = 0;
    int          m_cnt   = 0;
    int          m_age   = 0;
    int          m_lat   = 1;
    int          lat_max = 3;
    logic        m_iv    = 1'b0;
    logic        m_dv    = 1'b0;
    mem_in_type  m_ireq  = '0;
    mem_in_type  m_dreq  = '0;
    mem_in_type  m_issue = '0;

    mem_in_type  s_mem_in;
    mem_out_type s_imem_out, s_dmem_out;
    mem_in_type  issued[$];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic mem_in_type mk(logic [31:0] addr, logic [31:0] wdata,
                                      logic [3:0] wstrb, logic fence);
        mem_in_type q;
        q.mem_valid = 1'b1;
        q.mem_fence = fence;
        q.mem_instr = 1'b0;
        q.mem_addr  = addr;
        q.mem_wdata = wdata;
        q.mem_wstrb = wstrb;
        return q;
    endfunction

    function automatic mem_in_type rand_req(logic valid);
        mem_in_type q;
        q = mk($urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 7) == 0);
        q.mem_valid = valid;
        return q;
    endfunction

    function automatic void model_step(logic done);
        logic       iv, dv;
        mem_in_type ir, dr;
        int         side;
        if (!rst) begin
            m_iv = 1'b0; m_dv = 1'b0; m_owner = 0; m_cnt = 0; m_issue = '0;
            return;
        end
        iv = imem_in.mem_valid || m_iv;
        dv = dmem_in.mem_valid || m_dv;
        ir = imem_in.mem_valid ? imem_in : m_ireq;
        dr = dmem_in.mem_valid ? dmem_in : m_dreq;
        m_issue.mem_valid = 1'b0;
        if (m_owner != 0) begin
            if (done) m_owner = 0;
            else m_age++;
        end
        side = 0;
        if (m_owner == 0) begin
            if (iv && dv) side = (m_cnt == LIMIT) ? 1 : 2;
            else if (dv) side = 2;
            else if (iv) side = 1;
        end
        m_iv = iv; m_ireq = ir; m_dv = dv; m_dreq = dr;
        if (side == 1) begin
            m_issue = ir;
            m_issue.mem_instr = 1'b1;
            m_iv = 1'b0;
            m_cnt = 0;
        end
        if (side == 2) begin
            m_issue = dr;
            m_dv = 1'b0;
            if (iv) m_cnt++;
        end
        if (side != 0) begin
            m_issue.mem_valid = 1'b1;
            m_owner = side;
            m_age = 0;
            m_lat = $urandom_range(1, lat_max);
        end
    endfunction

    // Checks the current cycle at the falling edge, then advances the model.
    task automatic cycle();
        mem_out_type e_i, e_d;
        logic        done;
        @(negedge clk);
        s_mem_in   = mem_in;
        s_imem_out = imem_out;
        s_dmem_out = dmem_out;
        done = rst && m_owner != 0 && mem_out.mem_ready;
        e_i = '0;
        e_d = '0;
        if (done && m_owner == 1) e_i = mem_out;
        if (done && m_owner == 2) e_d = mem_out;
        chk("imem_out", 80'(imem_out), 80'(e_i));
        chk("dmem_out", 80'(dmem_out), 80'(e_d));
        chk("mem_valid", 80'(mem_in.mem_valid), 80'(m_issue.mem_valid));
        if (m_issue.mem_valid) chk("mem_in", 80'(mem_in), 80'(m_issue));
        if (mem_in.mem_valid === 1'b1) issued.push_back(mem_in);
        model_step(done);
        @(posedge clk);
        #1;
    endtask

    task automatic auto_mem(input int stray_pct);
        mem_out.mem_ready = 1'b0;
        mem_out.mem_rdata = $urandom;
        if (m_owner != 0 && m_age >= m_lat) mem_out.mem_ready = 1'b1;
        else if (m_owner == 0 && $urandom_range(0, 99) < stray_pct) mem_out.mem_ready = 1'b1;
    endtask

    task automatic drain();
        imem_in = '0;
        dmem_in = '0;
        for (int k = 0; k < 40; k++) begin
            if (m_owner == 0 && !m_iv && !m_dv) break;
            auto_mem(0);
            cycle();
        end
        mem_out = '0;
        cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n300, n400;
        logic posted;
        imem_in = '0; dmem_in = '0; mem_out = '0; rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (2) cycle();
        chk("reset_mem_in", 80'(s_mem_in), 80'(0));
        chk("reset_imem_out", 80'(s_imem_out), 80'(0));
        rst = 1'b1;
        cycle();

        // Single instruction fetch.
        imem_in = mk(32'h100, 32'h0, 4'h0, 1'b0);
        cycle();
        imem_in = '0;
        cycle();
        chk("fetch_valid", 80'(s_mem_in.mem_valid), 80'(1));
        chk("fetch_addr", 80'(s_mem_in.mem_addr), 80'(32'h100));
        chk("fetch_instr", 80'(s_mem_in.mem_instr), 80'(1));
        cycle();
        mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h0000_0013};
        cycle();
        chk("fetch_rsp_ready", 80'(s_imem_out.mem_ready), 80'(1));
        chk("fetch_rsp_rdata", 80'(s_imem_out.mem_rdata), 80'(32'h13));
        chk("fetch_d_quiet", 80'(s_dmem_out.mem_ready), 80'(0));
        mem_out = '0;
        cycle();

        // Simultaneous requests: data first, fetch after the data response.
        imem_in = mk(32'h200, 32'h0, 4'h0, 1'b0);
        dmem_in = mk(32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 1'b0);
        cycle();
        imem_in = '0; dmem_in = '0;
        cycle();
        chk("sim_d_addr", 80'(s_mem_in.mem_addr), 80'(32'h8000_0000));
        chk("sim_d_wdata", 80'(s_mem_in.mem_wdata), 80'(32'hDEAD_BEEF));
        chk("sim_d_wstrb", 80'(s_mem_in.mem_wstrb), 80'(4'hF));
        chk("sim_d_instr", 80'(s_mem_in.mem_instr), 80'(0));
        cycle();
        mem_out = '{mem_ready: 1'b1, mem_rdata: 32'hAAAA_0001};
        cycle();
        chk("sim_d_rsp", 80'(s_dmem_out.mem_ready), 80'(1));
        chk("sim_i_quiet", 80'(s_imem_out.mem_ready), 80'(0));
        mem_out = '0;
        cycle();
        chk("sim_i_valid", 80'(s_mem_in.mem_valid), 80'(1));
        chk("sim_i_addr", 80'(s_mem_in.mem_addr), 80'(32'h200));
        cycle();
        mem_out = '{mem_ready: 1'b1, mem_rdata: 32'hAAAA_0002};
        cycle();
        chk("sim_i_rsp", 80'(s_imem_out.mem_rdata), 80'(32'hAAAA_0002));
        mem_out = '0;
        cycle();

        // Starvation: data re-posted every cycle, fetch still gets every fifth grant.
        lat_max = 1;
        issued.delete();
        posted = 1'b0;
        imem_in = mk(32'h500, 32'h0, 4'h0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            dmem_in = mk(32'h9000 + 32'(k * 4), $urandom, 4'hF, 1'b0);
            auto_mem(0);
            cycle();
            imem_in = '0;
            if (!posted && s_mem_in.mem_valid && s_mem_in.mem_instr) begin
                posted = 1'b1;
                imem_in = mk(32'h600, 32'h0, 4'h0, 1'b0);
            end
        end
        chk("starve_count", 80'(issued.size() >= 10), 80'(1));
        for (int j = 0; j < 10 && j < issued.size(); j++)
            chk($sformatf("starve_seq%0d", j), 80'(issued[j].mem_instr), 80'(j == 4 || j == 9));
        drain();
        lat_max = 3;

        // Redirect: a second fetch address replaces the first while data is busy.
        issued.delete();
        dmem_in = mk(32'h1000, 32'h1, 4'h3, 1'b0);
        cycle();
        dmem_in = '0;
        cycle();
        imem_in = mk(32'h300, 32'h0, 4'h0, 1'b0);
        cycle();
        imem_in = mk(32'h400, 32'h0, 4'h0, 1'b0);
        cycle();
        imem_in = '0;
        mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h1234};
        cycle();
        mem_out = '0;
        cycle();
        chk("redirect_addr", 80'(s_mem_in.mem_addr), 80'(32'h400));
        drain();
        n300 = 0; n400 = 0;
        foreach (issued[j]) begin
            if (issued[j].mem_addr == 32'h300) n300++;
            if (issued[j].mem_addr == 32'h400 && issued[j].mem_instr) n400++;
        end
        chk("redirect_0x300", 80'(n300), 80'(0));
        chk("redirect_0x400", 80'(n400), 80'(1));

        // Reset while data is busy; a late ready must be ignored.
        dmem_in = mk(32'h2000, 32'h5, 4'hF, 1'b0);
        cycle();
        dmem_in = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h5555};
        cycle();
        chk("rst_d_quiet", 80'(s_dmem_out), 80'(0));
        chk("rst_i_quiet", 80'(s_imem_out), 80'(0));
        chk("rst_mem_in", 80'(s_mem_in), 80'(0));
        mem_out = '0;
        imem_in = mk(32'h10, 32'h0, 4'h0, 1'b0);
        cycle();
        imem_in = '0;
        cycle();
        chk("post_rst_valid", 80'(s_mem_in.mem_valid), 80'(1));
        chk("post_rst_addr", 80'(s_mem_in.mem_addr), 80'(32'h10));
        drain();

        // New data request captured in the cycle its previous response arrives.
        dmem_in = mk(32'h20, 32'h0, 4'h0, 1'b0);
        cycle();
        dmem_in = '0;
        cycle();
        cycle();
        dmem_in = mk(32'h40, 32'h0, 4'h0, 1'b1);
        mem_out = '{mem_ready: 1'b1, mem_rdata: 32'h77};
        cycle();
        chk("cor_rsp", 80'(s_dmem_out.mem_rdata), 80'(32'h77));
        dmem_in = '0;
        mem_out = '0;
        cycle();
        chk("cor_addr", 80'(s_mem_in.mem_addr), 80'(32'h40));
        chk("cor_fence", 80'(s_mem_in.mem_fence), 80'(1));
        drain();

        // Randomized traffic with stray readies and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            imem_in = rand_req($urandom_range(0, 3) == 0);
            dmem_in = rand_req($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) != 0);
            if (!rst) mem_out = '0;
            else auto_mem(10);
            cycle();
        end
        rst = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
